// File: rtl/pipelined_adder_sub.sv
// Pipelined two's-complement adder/subtractor: one SEG-bit segment is added per stage,
// with the carry registered between stages and a single global stall enable.
module pipelined_adder_sub #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / SEG;

    logic                en;
    logic [WIDTH-1:0]    bx;
    logic                c0;
    logic [SEG:0]        seg_sum [STAGES];

    logic [STAGES-1:0]   vld_p;
    logic [STAGES-1:0]   c_p;
    logic [WIDTH-1:0]    a_p  [STAGES];
    logic [WIDTH-1:0]    bx_p [STAGES];
    logic [WIDTH-1:0]    s_p  [STAGES];

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic ovf_f(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        bx         = sub ? ~b : b;
        c0         = sub | cin;
        seg_sum[0] = {1'b0, a[SEG-1:0]} + {1'b0, bx[SEG-1:0]} + {{SEG{1'b0}}, c0};
        for (int i = 1; i < STAGES; i++) begin
            seg_sum[i] = {1'b0, a_p[i-1][i*SEG +: SEG]}
                       + {1'b0, bx_p[i-1][i*SEG +: SEG]}
                       + {{SEG{1'b0}}, c_p[i-1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
            c_p   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                a_p[i]  <= '0;
                bx_p[i] <= '0;
                s_p[i]  <= '0;
            end
        end else if (en) begin
            // stage 0: capture operands and add segment 0
            vld_p[0]          <= in_valid;
            a_p[0]            <= a;
            bx_p[0]           <= bx;
            s_p[0]            <= '0;
            s_p[0][SEG-1:0]   <= seg_sum[0][SEG-1:0];
            c_p[0]            <= seg_sum[0][SEG];
            // stage i: forward lower segments, insert segment i
            for (int i = 1; i < STAGES; i++) begin
                vld_p[i]               <= vld_p[i-1];
                a_p[i]                 <= a_p[i-1];
                bx_p[i]                <= bx_p[i-1];
                s_p[i]                 <= s_p[i-1];
                s_p[i][i*SEG +: SEG]   <= seg_sum[i][SEG-1:0];
                c_p[i]                 <= seg_sum[i][SEG];
            end
        end
    end

    assign out_valid = vld_p[STAGES-1];
    assign sum       = s_p[STAGES-1];
    assign cout      = c_p[STAGES-1];
    assign ovf       = ovf_f(a_p[STAGES-1][WIDTH-1], bx_p[STAGES-1][WIDTH-1],
                             s_p[STAGES-1][WIDTH-1]);

endmodule

// File: doc/pipelined_adder_sub.md
# pipelined_adder_sub

Parametrised, pipelined two's-complement adder/subtractor that generalises the team's ripple-carry adders. It splits a WIDTH-bit add into SEG-bit segments, adds one segment per clock, and registers the carry between stages. It accepts one operand pair per cycle through a valid/ready handshake and returns sum, carry-out and signed overflow a fixed number of cycles later. It is the arithmetic datapath element for wide adds that do not close timing as a single ripple chain.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of SEG.
- SEG, 8, bits added per pipeline stage; STAGES = WIDTH/SEG (default 4).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset. Clears all state immediately.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block can accept this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in, used when sub=0.
- sub  input  1  1 = compute a - b; 0 = compute a + b + cin.
- out_valid  output  1  result presented.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB. When sub=1, cout=1 means no borrow.
- ovf  output  1  signed overflow.

## Operation
- Effective operands:
  - B' = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
  - Result = a + B' + c0, computed modulo 2^WIDTH.
- Pipeline of STAGES register stages, each with a valid bit.
  - Stage 0 captures a, B', the sign bits, and the sum and carry of segment 0 from c0.
  - Stage i adds segment i using the registered carry from stage i-1. It forwards previously computed low segments unchanged and carries the not-yet-added high segments forward.
  - Segment i is bits [i*SEG+SEG-1 : i*SEG].
- The final stage drives sum, cout and out_valid.
  - ovf = (a[W-1] == B'[W-1]) && (sum[W-1] != a[W-1]), using the stage-0 captured signs.
- Global advance enable: en = !out_valid || out_ready.
  - in_ready = en. It is a combinational function of out_valid and out_ready only, and never depends on in_valid.
  - When en=1, every stage loads from its predecessor. Stage 0 loads in_valid.
  - When en=0, every stage holds, including its data.
- Bubbles are not collapsed. A stage with valid=0 still advances.
- Output data is held stable while out_valid=1 && out_ready=0.
- STAGES=1 is legal: the block degenerates to a single registered adder.

## Timing
- Reset values: out_valid=0, sum=0, cout=0, ovf=0. All stage valid bits and data registers are 0.
- in_ready=1 after reset, because out_valid=0.
- Latency:
  - A pair accepted at rising edge N appears with out_valid=1 after edge N+STAGES-1, provided there are no stalls.
  - That is STAGES cycles from acceptance to first visibility.
  - Each stall cycle adds exactly one cycle.
- Throughput: one result per cycle while out_ready stays high.
- Transfer rules:
  - Input transfer occurs on an edge with in_valid && in_ready.
  - Output transfer occurs on an edge with out_valid && out_ready.
  - With a full pipeline and out_ready=1, input and output transfers occur on the same edge.
- Wrap-around: sum wraps modulo 2^WIDTH, and cout captures the lost bit.
- Reset mid-operation: asserting rst asynchronously flushes all in-flight results. Nothing is emitted for them. After rst deasserts, the first edge may accept new input.
- Signals are sampled only on clk edges. sub and cin must be valid only on the accepting edge.

## Test plan
- WIDTH=32, SEG=8, out_ready=1: accept a=0x0000_00FF, b=0x0000_0001, sub=0, cin=0. 4 cycles later expect sum=0x0000_0100, cout=0, ovf=0. This checks the carry crossing segments 0 to 1.
- Full carry ripple: a=0xFFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0. Signed overflow: a=0x7FFF_FFFF, b=1, cin=0 -> sum=0x8000_0000, ovf=1, cout=0.
- Subtract:
  - a=5, b=7, sub=1 -> sum=0xFFFF_FFFE, cout=0 (borrow), ovf=0.
  - a=0x8000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF, ovf=1, cout=1.
- Back-to-back streaming: 100 random pairs on consecutive cycles with random sub/cin. Expect one result per cycle starting at cycle 4, in order, matching the reference model.
- Backpressure: drop out_ready for 3 cycles with a full pipeline.
  - in_ready=0 during the stall, and sum is held constant.
  - After release, no loss or duplication. Total latency of the stalled items is 4+3.
- Assert rst with 3 items in flight. Expect out_valid=0 immediately (asynchronous), no stale output afterwards, and a correct result for the next input accepted 4 cycles later. Repeat with WIDTH=16, SEG=4 and with STAGES=1.
